// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode between fetch and execute.
// Each accepted instruction word is decoded combinationally. The result is
// captured into a 1-entry pipeline register or a 2-entry skid buffer, and
// that buffer has its own valid/ready handshake toward execute.
module decode_stage #(
    parameter int XLEN         = 32,
    parameter int BUFFER_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            instr_valid_i,
    output logic            instr_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            dec_valid_o,
    input  logic            dec_ready_i,
    output logic [XLEN-1:0] dec_pc_o,
    output logic [3:0]      dec_class_o,
    output logic [4:0]      dec_rd_o,
    output logic [4:0]      dec_rs1_o,
    output logic [4:0]      dec_rs2_o,
    output logic [2:0]      dec_funct3_o,
    output logic            dec_funct7b5_o,
    output logic [XLEN-1:0] dec_imm_o,
    output logic            dec_is_imm_o,
    output logic            dec_illegal_o
);

    typedef enum logic [3:0] {
        CLS_LUI     = 4'd0,
        CLS_AUIPC   = 4'd1,
        CLS_JAL     = 4'd2,
        CLS_JALR    = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_LOAD    = 4'd5,
        CLS_STORE   = 4'd6,
        CLS_OP_IMM  = 4'd7,
        CLS_OP      = 4'd8,
        CLS_FENCE   = 4'd9,
        CLS_SYSTEM  = 4'd10,
        CLS_ILLEGAL = 4'd15
    } cls_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        cls_e            cls;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic [XLEN-1:0] imm;
        logic            is_imm;
        logic            illegal;
    } entry_t;

    if (XLEN < 32) begin : g_bad_xlen
        $error("decode_stage: XLEN must be at least 32");
    end

    // Sign-extend a 32-bit immediate to XLEN without zero-width replications.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u  = {instr_i[31:12], 12'b0};
    assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    assign imm_sh = {27'b0, instr_i[24:20]};

    entry_t dec_entry;

    // Classify the incoming word, pick its immediate and apply the illegal override.
    always_comb begin
        logic [31:0] imm32;
        logic        bad;
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        dec_entry          = '0;
        dec_entry.cls      = CLS_ILLEGAL;
        dec_entry.pc       = pc_i;
        dec_entry.rd       = instr_i[11:7];
        dec_entry.rs1      = instr_i[19:15];
        dec_entry.rs2      = instr_i[24:20];
        dec_entry.funct3   = funct3;
        dec_entry.funct7b5 = instr_i[30];
        imm32              = 32'd0;
        bad                = 1'b0;

        // opcode includes instr[1:0], so a non-11 low pair falls into default.
        case (opcode)
            7'b0110111: begin
                dec_entry.cls    = CLS_LUI;
                imm32            = imm_u;
                dec_entry.is_imm = 1'b1;
            end
            7'b0010111: begin
                dec_entry.cls    = CLS_AUIPC;
                imm32            = imm_u;
                dec_entry.is_imm = 1'b1;
            end
            7'b1101111: begin
                dec_entry.cls = CLS_JAL;
                imm32         = imm_j;
            end
            7'b1100111: begin
                dec_entry.cls    = CLS_JALR;
                imm32            = imm_i;
                dec_entry.is_imm = 1'b1;
                bad              = (funct3 != 3'b000);
            end
            7'b1100011: begin
                dec_entry.cls = CLS_BRANCH;
                imm32         = imm_b;
                bad           = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            7'b0000011: begin
                dec_entry.cls    = CLS_LOAD;
                imm32            = imm_i;
                dec_entry.is_imm = 1'b1;
                bad              = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            7'b0100011: begin
                dec_entry.cls    = CLS_STORE;
                imm32            = imm_s;
                dec_entry.is_imm = 1'b1;
                bad              = (funct3 >= 3'b011);
            end
            7'b0010011: begin
                dec_entry.cls    = CLS_OP_IMM;
                dec_entry.is_imm = 1'b1;
                if (funct3 == 3'b001) begin
                    imm32 = imm_sh;
                    bad   = (funct7 != 7'h00);
                end else if (funct3 == 3'b101) begin
                    imm32 = imm_sh;
                    bad   = (funct7 != 7'h00) && (funct7 != 7'h20);
                end else begin
                    imm32 = imm_i;
                end
            end
            7'b0110011: begin
                dec_entry.cls = CLS_OP;
                bad = !((funct7 == 7'h00) ||
                        ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            7'b0001111: begin
                dec_entry.cls = CLS_FENCE;
            end
            7'b1110011: begin
                dec_entry.cls = CLS_SYSTEM;
                imm32         = imm_i;
            end
            default: begin
                bad = 1'b1;
            end
        endcase

        dec_entry.imm = sext32(imm32);
        if (bad) begin
            dec_entry.cls     = CLS_ILLEGAL;
            dec_entry.imm     = '0;
            dec_entry.is_imm  = 1'b0;
            dec_entry.illegal = 1'b1;
        end
    end

    logic   push;
    logic   pop;
    entry_t head_q;

    // A flush cancels both the accept and the pop of the same cycle.
    assign push = instr_valid_i && instr_ready_o && !flush_i;
    assign pop  = dec_valid_o && dec_ready_i && !flush_i;

    if (BUFFER_DEPTH == 1) begin : g_pipe
        logic valid_q;

        // Single pipeline register: load on push, empty on pop or flush.
        always_ff @(posedge clk or posedge rst) begin
            // NOTE: stored entries are reset too, so the data outputs read 0 after reset.
            if (rst) begin
                valid_q <= 1'b0;
                head_q  <= '0;
            end else if (flush_i) begin
                // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
                valid_q <= 1'b0;
            end else if (push) begin
                valid_q <= 1'b1;
                head_q  <= dec_entry;
            end else if (pop) begin
                valid_q <= 1'b0;
            end
        end

        assign dec_valid_o   = valid_q;
        assign instr_ready_o = !valid_q || dec_ready_i;
    end else if (BUFFER_DEPTH == 2) begin : g_skid
        entry_t     skid_q;
        logic [1:0] count_q;
        logic [1:0] count_d;
        logic       ready_q;

        // Next occupancy: a push and a pop together cancel out.
        always_comb begin
            count_d = count_q;
            if (flush_i) begin
                count_d = 2'd0;
            end else begin
                case ({push, pop})
                    2'b10:   count_d = count_q + 2'd1;
                    2'b01:   count_d = count_q - 2'd1;
                    default: count_d = count_q;
                endcase
            end
        end

        // Skid storage, occupancy and a registered ready that cuts dec_ready_i out of instr_ready_o.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                count_q <= 2'd0;
                ready_q <= 1'b1;
                head_q  <= '0;
                skid_q  <= '0;
            end else begin
                count_q <= count_d;
                ready_q <= (count_d < 2'd2);
                if (!flush_i) begin
                    if (push && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
                        head_q <= dec_entry;
                    end else if (pop && (count_q == 2'd2)) begin
                        head_q <= skid_q;
                    end
                    if (push && (count_q == 2'd1) && !pop) begin
                        skid_q <= dec_entry;
                    end
                end
            end
        end

        assign dec_valid_o   = (count_q != 2'd0);
        assign instr_ready_o = ready_q;
    end else begin : g_bad_depth
        $error("decode_stage: BUFFER_DEPTH must be 1 or 2");
    end

    assign dec_pc_o       = head_q.pc;
    assign dec_class_o    = head_q.cls;
    assign dec_rd_o       = head_q.rd;
    assign dec_rs1_o      = head_q.rs1;
    assign dec_rs2_o      = head_q.rs2;
    assign dec_funct3_o   = head_q.funct3;
    assign dec_funct7b5_o = head_q.funct7b5;
    assign dec_imm_o      = head_q.imm;
    assign dec_is_imm_o   = head_q.is_imm;
    assign dec_illegal_o  = head_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table-driven decode vectors checked through a scoreboard
// queue, plus hand-written backpressure, flush and async-reset sequences.
module tb_decode_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush_i;
    logic            instr_valid_i;
    logic            instr_ready_o;
    logic [31:0]     instr_i;
    logic [XLEN-1:0] pc_i;
    logic            dec_valid_o;
    logic            dec_ready_i;
    logic [XLEN-1:0] dec_pc_o;
    logic [3:0]      dec_class_o;
    logic [4:0]      dec_rd_o;
    logic [4:0]      dec_rs1_o;
    logic [4:0]      dec_rs2_o;
    logic [2:0]      dec_funct3_o;
    logic            dec_funct7b5_o;
    logic [XLEN-1:0] dec_imm_o;
    logic            dec_is_imm_o;
    logic            dec_illegal_o;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(XLEN), .BUFFER_DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .instr_i       (instr_i),
        .pc_i          (pc_i),
        .dec_valid_o   (dec_valid_o),
        .dec_ready_i   (dec_ready_i),
        .dec_pc_o      (dec_pc_o),
        .dec_class_o   (dec_class_o),
        .dec_rd_o      (dec_rd_o),
        .dec_rs1_o     (dec_rs1_o),
        .dec_rs2_o     (dec_rs2_o),
        .dec_funct3_o  (dec_funct3_o),
        .dec_funct7b5_o(dec_funct7b5_o),
        .dec_imm_o     (dec_imm_o),
        .dec_is_imm_o  (dec_is_imm_o),
        .dec_illegal_o (dec_illegal_o)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [3:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic        f7b5;
        logic [31:0] imm;
        logic        is_imm;
        logic        ill;
    } exp_t;

    localparam int NVEC = 17;

    exp_t vec [NVEC];
    exp_t q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   pops = 0;
    int   cycles = 0;
    bit   last_accept;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Raw fields come straight from the bit positions; class/imm/flags are hand-written.
    function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [3:0] cls, input logic [31:0] imm,
                                input logic is_imm, input logic ill);
        exp_t e;
        e.instr  = instr;
        e.pc     = pc;
        e.cls    = cls;
        e.rd     = instr[11:7];
        e.rs1    = instr[19:15];
        e.rs2    = instr[24:20];
        e.f3     = instr[14:12];
        e.f7b5   = instr[30];
        e.imm    = imm;
        e.is_imm = is_imm;
        e.ill    = ill;
        return e;
    endfunction

    // Sampled mid-cycle: compare a popped head against the scoreboard, record accepts.
    task automatic observe();
        exp_t e;
        last_accept = instr_valid_i && instr_ready_o && !flush_i;
        if (flush_i) begin
            q.delete();
        end else if (dec_valid_o && dec_ready_i) begin
            pops++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: pc 0x%0h emitted, none expected", dec_pc_o);
            end else begin
                e = q.pop_front();
                check("pc",      dec_pc_o,       e.pc);
                check("class",   dec_class_o,    e.cls);
                check("rd",      dec_rd_o,       e.rd);
                check("rs1",     dec_rs1_o,      e.rs1);
                check("rs2",     dec_rs2_o,      e.rs2);
                check("funct3",  dec_funct3_o,   e.f3);
                check("f7b5",    dec_funct7b5_o, e.f7b5);
                check("imm",     dec_imm_o,      e.imm);
                check("is_imm",  dec_is_imm_o,   e.is_imm);
                check("illegal", dec_illegal_o,  e.ill);
            end
        end
        if (last_accept) q.push_back(cur);
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        cycles++;
    endtask

    // Offer one instruction until accepted or the budget runs out; valid stays high.
    task automatic offer(input exp_t e, input int max_cycles);
        instr_valid_i = 1'b1;
        instr_i       = e.instr;
        pc_i          = e.pc;
        cur           = e;
        last_accept   = 1'b0;
        for (int n = 0; n < max_cycles; n++) begin
            tick();
            if (last_accept) break;
        end
        check("accepted", last_accept, 1'b1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_pc"},  dec_pc_o,  32'd0);
        check({tag, "_imm"}, dec_imm_o, 32'd0);
        check({tag, "_fields"}, {7'd0, dec_class_o, dec_rd_o, dec_rs1_o, dec_rs2_o,
                                 dec_funct3_o, dec_funct7b5_o, dec_is_imm_o, dec_illegal_o}, 32'd0);
    endtask

    initial begin
        int p0;
        int c0;

        vec[0]  = mk(32'hFFB10093, 32'h100, 4'd7,  32'hFFFFFFFB, 1'b1, 1'b0); // addi x1,x2,-5
        vec[1]  = mk(32'h00532423, 32'h104, 4'd6,  32'h00000008, 1'b1, 1'b0); // sw x5,8(x6)
        vec[2]  = mk(32'hFE208EE3, 32'h108, 4'd4,  32'hFFFFFFFC, 1'b0, 1'b0); // beq -4
        vec[3]  = mk(32'h123451B7, 32'h10C, 4'd0,  32'h12345000, 1'b1, 1'b0); // lui
        vec[4]  = mk(32'h001000EF, 32'h110, 4'd2,  32'h00000800, 1'b0, 1'b0); // jal 2048
        vec[5]  = mk(32'h4030D093, 32'h114, 4'd7,  32'h00000003, 1'b1, 1'b0); // srai
        vec[6]  = mk(32'h00000000, 32'h118, 4'd15, 32'h00000000, 1'b0, 1'b1); // low bits 00
        vec[7]  = mk(32'h00001067, 32'h11C, 4'd15, 32'h00000000, 1'b0, 1'b1); // jalr f3=1
        vec[8]  = mk(32'h02000033, 32'h120, 4'd15, 32'h00000000, 1'b0, 1'b1); // add f7=0x01
        vec[9]  = mk(32'h0000006F, 32'h124, 4'd2,  32'h00000000, 1'b0, 1'b0); // jal x0,0
        vec[10] = mk(32'h00001297, 32'h128, 4'd1,  32'h00001000, 1'b1, 1'b0); // auipc
        vec[11] = mk(32'hFFF12083, 32'h12C, 4'd5,  32'hFFFFFFFF, 1'b1, 1'b0); // lw -1
        vec[12] = mk(32'h403100B3, 32'h130, 4'd8,  32'h00000000, 1'b0, 1'b0); // sub
        vec[13] = mk(32'h00000073, 32'h134, 4'd10, 32'h00000000, 1'b0, 1'b0); // ecall
        vec[14] = mk(32'h0FF0000F, 32'h138, 4'd9,  32'h00000000, 1'b0, 1'b0); // fence
        vec[15] = mk(32'h40109093, 32'h13C, 4'd15, 32'h00000000, 1'b0, 1'b1); // slli f7=0x20
        vec[16] = mk(32'h402090B3, 32'h140, 4'd15, 32'h00000000, 1'b0, 1'b1); // sll f7=0x20

        rst           = 1'b1;
        flush_i       = 1'b0;
        instr_valid_i = 1'b0;
        instr_i       = 32'd0;
        pc_i          = 32'd0;
        dec_ready_i   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_valid", dec_valid_o, 1'b0);
        check("rst_ready", instr_ready_o, 1'b1);
        check_zero_outputs("rst");
        @(posedge clk);
        #1;

        // Basic decode and one-cycle latency.
        dec_ready_i = 1'b1;
        offer(vec[0], 4);
        instr_valid_i = 1'b0;
        check("latency_valid", dec_valid_o, 1'b1);
        tick();

        // Back-to-back stream of the remaining table at full throughput.
        c0 = cycles;
        for (int i = 1; i < NVEC; i++) offer(vec[i], 4);
        check("throughput_cycles", cycles - c0, NVEC - 1);
        instr_valid_i = 1'b0;
        repeat (3) tick();
        check("stream_drained", q.size(), 0);

        // Backpressure: two accepted, third held, head stable, ordered drain.
        dec_ready_i = 1'b0;
        offer(vec[1], 2);
        offer(vec[2], 2);
        instr_i = vec[3].instr;
        pc_i    = vec[3].pc;
        cur     = vec[3];
        check("ready_low_when_full", instr_ready_o, 1'b0);
        for (int n = 0; n < 3; n++) begin
            tick();
            check("stall_no_accept", last_accept, 1'b0);
            check("stall_valid", dec_valid_o, 1'b1);
            check("stall_head_pc", dec_pc_o, vec[1].pc);
            check("stall_head_imm", dec_imm_o, vec[1].imm);
        end
        dec_ready_i = 1'b1;
        p0 = pops;
        for (int n = 0; n < 3; n++) begin
            tick();
            if (last_accept) instr_valid_i = 1'b0;
        end
        check("drain_no_bubble", pops - p0, 3);
        check("drain_empty", q.size(), 0);
        instr_valid_i = 1'b0;

        // Flush at occupancy 2 with an instruction offered.
        dec_ready_i = 1'b0;
        offer(vec[4], 2);
        offer(vec[5], 2);
        instr_i = vec[6].instr;
        pc_i    = vec[6].pc;
        cur     = vec[6];
        flush_i = 1'b1;
        tick();
        check("flush_no_accept", last_accept, 1'b0);
        flush_i       = 1'b0;
        instr_valid_i = 1'b0;
        check("flush_valid", dec_valid_o, 1'b0);
        check("flush_ready", instr_ready_o, 1'b1);
        dec_ready_i = 1'b1;
        repeat (3) tick();

        // Flush at occupancy 1 while ready is high: the offered word is dropped too.
        dec_ready_i = 1'b0;
        offer(vec[7], 2);
        instr_i     = vec[8].instr;
        pc_i        = vec[8].pc;
        cur         = vec[8];
        dec_ready_i = 1'b1;
        flush_i     = 1'b1;
        tick();
        check("flush1_no_accept", last_accept, 1'b0);
        flush_i       = 1'b0;
        instr_valid_i = 1'b0;
        check("flush1_valid", dec_valid_o, 1'b0);
        offer(vec[9], 2);
        instr_valid_i = 1'b0;
        repeat (2) tick();
        check("flush_recover_empty", q.size(), 0);

        // Asynchronous reset between edges with one entry held.
        dec_ready_i = 1'b0;
        offer(vec[10], 2);
        instr_valid_i = 1'b0;
        check("pre_reset_valid", dec_valid_o, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", dec_valid_o, 1'b0);
        check("async_rst_ready", instr_ready_o, 1'b1);
        check_zero_outputs("async_rst");
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        dec_ready_i = 1'b1;
        offer(vec[11], 2);
        instr_valid_i = 1'b0;
        repeat (2) tick();
        check("final_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
